// File: rtl/gamma_pixel_xlate.sv
// Gamma correction of 8-bit linear RGB pixels to 16-bit components through an
// external single-port gamma RAM, with a per-pixel bypass that expands the bytes directly.
module gamma_pixel_xlate #(
  parameter int BYPASS_EXPAND = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  input  logic        in_bypass,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_rgb,
  output logic [7:0]  lut_adb,
  output logic        lut_ceb,
  output logic        lut_oce,
  input  logic [15:0] lut_dout
);

  typedef enum logic [2:0] {
    IDLE,
    RD_R,
    RD_G,
    RD_B,
    LAST,
    OUT
  } state_t;

  state_t      state;
  logic [15:0] pix_gb;
  logic [15:0] r16;
  logic [15:0] g16;

  function automatic logic [15:0] expand(input logic [7:0] c);
    return (BYPASS_EXPAND != 0) ? {c, c} : {c, 8'h00};
  endfunction

  assign lut_oce = 1'b1;

  // The RAM returns data one cycle after each read, so every read state
  // presents the next address while capturing the previous component.
  // All handshake and RAM controls are flops, keeping the ports free of
  // combinational paths from in_valid/out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lut_ceb   <= 1'b0;
      lut_adb   <= 8'h00;
      out_rgb   <= 48'h0;
      pix_gb    <= 16'h0;
      r16       <= 16'h0;
      g16       <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            pix_gb   <= in_rgb[15:0];
            if (in_bypass) begin
              out_rgb   <= {expand(in_rgb[23:16]), expand(in_rgb[15:8]), expand(in_rgb[7:0])};
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              lut_ceb <= 1'b1;
              lut_adb <= in_rgb[23:16];
              state   <= RD_R;
            end
          end
        end
        RD_R: begin
          lut_adb <= pix_gb[15:8];
          state   <= RD_G;
        end
        RD_G: begin
          r16     <= lut_dout;
          lut_adb <= pix_gb[7:0];
          state   <= RD_B;
        end
        RD_B: begin
          g16     <= lut_dout;
          lut_ceb <= 1'b0;
          state   <= LAST;
        end
        LAST: begin
          out_rgb   <= {r16, g16, lut_dout};
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          lut_ceb   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_pixel_xlate.sv
// Directed bench for gamma_pixel_xlate: LUT path, bypass in both expansion
// modes, output stall, back-to-back throughput and reset in mid-pixel.
module tb_gamma_pixel_xlate;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_rgb;
  logic        in_bypass;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_rgb;
  logic [7:0]  lut_adb;
  logic        lut_ceb;
  logic        lut_oce;
  logic [15:0] lut_dout;

  logic        in_valid_z;
  logic        in_ready_z;
  logic        out_valid_z;
  logic        out_ready_z;
  logic [47:0] out_rgb_z;
  logic [7:0]  lut_adb_z;
  logic        lut_ceb_z;
  logic        lut_oce_z;
  logic [15:0] lut_dout_z;

  int n_compared   = 0;
  int n_mismatched = 0;

  gamma_pixel_xlate #(.BYPASS_EXPAND(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rgb(in_rgb), .in_bypass(in_bypass), .out_valid(out_valid),
    .out_ready(out_ready), .out_rgb(out_rgb), .lut_adb(lut_adb),
    .lut_ceb(lut_ceb), .lut_oce(lut_oce), .lut_dout(lut_dout)
  );

  gamma_pixel_xlate #(.BYPASS_EXPAND(0)) dut_zero (
    .clk(clk), .reset(reset), .in_valid(in_valid_z), .in_ready(in_ready_z),
    .in_rgb(in_rgb), .in_bypass(in_bypass), .out_valid(out_valid_z),
    .out_ready(out_ready_z), .out_rgb(out_rgb_z), .lut_adb(lut_adb_z),
    .lut_ceb(lut_ceb_z), .lut_oce(lut_oce_z), .lut_dout(lut_dout_z)
  );

  always #5 clk = ~clk;

  // Gamma RAM model: one-cycle read latency, dout = {~adb, adb}.
  always @(posedge clk) begin
    if (lut_ceb) lut_dout <= {~lut_adb, lut_adb};
  end

  task automatic run_lut_pixel(input logic [23:0] rgb, input logic [47:0] exp_rgb, input string name);
    logic [7:0] reads [3];
    logic [7:0] exp_adb [3];
    int n_reads = 0;
    int lat = 0;
    exp_adb[0] = rgb[23:16];
    exp_adb[1] = rgb[15:8];
    exp_adb[2] = rgb[7:0];
    for (int i = 0; i < 3; i++) reads[i] = 8'h00;
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL %s ready_before: got %b want 1", name, in_ready);
    end
    in_rgb = rgb; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (lut_ceb) begin
        if (n_reads < 3) reads[n_reads] = lut_adb;
        n_reads++;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    n_compared++;
    if (lat !== 5) begin
      n_mismatched++;
      $display("[TB] FAIL %s latency: got %0d want 5", name, lat);
    end
    n_compared++;
    if (n_reads !== 3) begin
      n_mismatched++;
      $display("[TB] FAIL %s read_count: got %0d want 3", name, n_reads);
    end
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (reads[i] !== exp_adb[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s adb[%0d]: got %h want %h", name, i, reads[i], exp_adb[i]);
      end
    end
    n_compared++;
    if (out_rgb !== exp_rgb) begin
      n_mismatched++;
      $display("[TB] FAIL %s out_rgb: got %h want %h", name, out_rgb, exp_rgb);
    end
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL %s release: got ready=%b valid=%b want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_rgb = 24'h123456; in_bypass = 1'b1;
    out_ready = 1'b1; in_valid_z = 1'b0; out_ready_z = 1'b1; lut_dout_z = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    n_compared++;
    if (lut_ceb !== 1'b0 || lut_adb !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_lut: got ceb=%b adb=%h want 0/00", lut_ceb, lut_adb);
    end
    n_compared++;
    if (out_rgb !== 48'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_rgb: got %h want 0", out_rgb);
    end
    n_compared++;
    if (lut_oce !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL lut_oce: got %b want 1", lut_oce);
    end
    reset = 1'b0; in_valid = 1'b0; in_bypass = 1'b0;
  endtask

  task automatic test_lut_path();
    run_lut_pixel(24'h10_80_FF, 48'hEF10_7F80_00FF, "lut_basic");
    run_lut_pixel(24'h00_5A_C3, 48'hFF00_A55A_3CC3, "lut_second");
  endtask

  task automatic test_bypass();
    int saw_ceb = 0;
    @(negedge clk);
    n_compared++;
    if (in_ready_z !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL bypass_zero_ready: got %b want 1", in_ready_z);
    end
    in_rgb = 24'hA5_00_3C; in_bypass = 1'b1; in_valid = 1'b1; in_valid_z = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_valid_z = 1'b0; in_bypass = 1'b0;
    @(negedge clk);
    if (lut_ceb || lut_ceb_z) saw_ceb++;
    n_compared++;
    if (out_valid !== 1'b1 || out_rgb !== 48'hA5A5_0000_3C3C) begin
      n_mismatched++;
      $display("[TB] FAIL bypass_repl: got valid=%b rgb=%h want 1/a5a500003c3c", out_valid, out_rgb);
    end
    n_compared++;
    if (out_valid_z !== 1'b1 || out_rgb_z !== 48'hA500_0000_3C00) begin
      n_mismatched++;
      $display("[TB] FAIL bypass_zpad: got valid=%b rgb=%h want 1/a50000003c00", out_valid_z, out_rgb_z);
    end
    @(negedge clk);
    if (lut_ceb || lut_ceb_z) saw_ceb++;
    n_compared++;
    if (saw_ceb !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL bypass_no_read: got %0d ceb cycles want 0", saw_ceb);
    end
    n_compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL bypass_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_stall();
    int found = 0;
    int bad_valid = 0;
    int bad_rgb = 0;
    int bad_ready = 0;
    int bad_ceb = 0;
    @(negedge clk);
    in_rgb = 24'h10_80_FF; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      in_rgb = $urandom;
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    n_compared++;
    if (found !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL stall_reach_out: got %0d want 1", found);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_rgb = $urandom;
      if (out_valid !== 1'b1) bad_valid++;
      if (out_rgb !== 48'hEF10_7F80_00FF) bad_rgb++;
      if (in_ready !== 1'b0) bad_ready++;
      if (lut_ceb !== 1'b0) bad_ceb++;
    end
    n_compared++;
    if (bad_valid !== 0 || bad_rgb !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL stall_hold: got %0d/%0d bad valid/rgb cycles want 0/0", bad_valid, bad_rgb);
    end
    n_compared++;
    if (bad_ready !== 0 || bad_ceb !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL stall_quiet: got %0d/%0d bad ready/ceb cycles want 0/0", bad_ready, bad_ceb);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL stall_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pix [3];
    logic [47:0] exp_rgb [3];
    int out_cycle [3];
    int n_in = 0;
    int n_out = 0;
    pix[0] = 24'h00_01_02; exp_rgb[0] = 48'hFF00_FE01_FD02;
    pix[1] = 24'h7F_C3_55; exp_rgb[1] = 48'h807F_3CC3_AA55;
    pix[2] = 24'hFF_FE_20; exp_rgb[2] = 48'h00FF_01FE_DF20;
    out_ready = 1'b1; in_bypass = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (n_out < 3) begin
          out_cycle[n_out] = c;
          n_compared++;
          if (out_rgb !== exp_rgb[n_out]) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_rgb[%0d]: got %h want %h", n_out, out_rgb, exp_rgb[n_out]);
          end
        end
        n_out++;
      end
      if (in_ready) begin
        if (n_in < 3) begin
          in_rgb = pix[n_in];
          in_valid = 1'b1;
          n_in++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    n_compared++;
    if (n_out !== 3) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_count: got %0d want 3", n_out);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_compared++;
        if (out_cycle[i] - out_cycle[i-1] !== 6) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_period[%0d]: got %0d want 6", i, out_cycle[i] - out_cycle[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int saw_valid = 0;
    @(negedge clk);
    in_rgb = 24'h44_55_66; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_rgb = 24'h99_99_99;
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b1 || lut_ceb !== 1'b0 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_state: got ready=%b ceb=%b valid=%b want 1/0/0", in_ready, lut_ceb, out_valid);
    end
    reset = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) saw_valid++;
    end
    n_compared++;
    if (saw_valid !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_discard: got %0d valid cycles want 0", saw_valid);
    end
    run_lut_pixel(24'h33_CC_01, 48'hCC33_33CC_FE01, "after_reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_lut_path();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/gamma_pixel_xlate.md
GAMMA_PIXEL_XLATE -- requirements
Module: gamma_pixel_xlate

Interface
REQ-001 The module SHALL have parameter BYPASS_EXPAND, default 1, which selects the bypass 8->16 expansion: 1 = byte replication {c,c}, 0 = zero-pad {c,8'h00}.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: upstream pixel valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the module accepts a pixel.
REQ-006 The module SHALL have port in_rgb, input, 24 bits: {R[23:16],G[15:8],B[7:0]}, 8-bit linear components.
REQ-007 The module SHALL have port in_bypass, input, 1 bit: when high at acceptance, the pixel skips the LUT.
REQ-008 The module SHALL have port out_valid, output, 1 bit: the corrected pixel is valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: downstream accepts the pixel.
REQ-010 The module SHALL have port out_rgb, output, 48 bits: {R16,G16,B16}, gamma-corrected 16-bit components.
REQ-011 The module SHALL have port lut_adb, output, 8 bits: gamma RAM read address.
REQ-012 The module SHALL have port lut_ceb, output, 1 bit: gamma RAM read clock enable.
REQ-013 The module SHALL have port lut_oce, output, 1 bit: gamma RAM output clock enable, held constantly at 1.
REQ-014 The module SHALL have port lut_dout, input, 16 bits: gamma RAM read data, valid exactly 1 cycle after the edge on which lut_ceb=1 and lut_adb are sampled.

Function
REQ-015 Handshakes SHALL transfer on a rising edge where valid&&ready=1; a pixel SHALL be processed only when a handshake transfers it.
REQ-016 FSM states SHALL be IDLE, RD_R, RD_G, RD_B, LAST and OUT.
REQ-017 in_ready SHALL be 1 only in IDLE; in every other state it SHALL be 0.
REQ-018 IDLE: on an input handshake, in_rgb and in_bypass SHALL be registered, and the next state SHALL be RD_R if bypass=0, else OUT.
REQ-019 RD_R: the block SHALL drive lut_ceb=1 with lut_adb=R, then go to RD_G.
REQ-020 RD_G: the block SHALL drive lut_ceb=1 with lut_adb=G, capture lut_dout into R16, then go to RD_B.
REQ-021 RD_B: the block SHALL drive lut_ceb=1 with lut_adb=B, capture lut_dout into G16, then go to LAST.
REQ-022 LAST: the block SHALL drive lut_ceb=0, capture lut_dout into B16, then go to OUT.
REQ-023 OUT: out_valid SHALL be 1 and out_rgb SHALL be stable; on an output handshake the state SHALL become IDLE, otherwise OUT is held indefinitely.
REQ-024 lut_ceb SHALL be 0 in IDLE, LAST and OUT; lut_adb SHALL hold its last value when lut_ceb=0.
REQ-025 LUT-path latency SHALL be: handshake at edge T -> out_valid=1 in the cycle after edge T+4 (5 cycles); minimum pixel period is 6 cycles with out_ready tied high.
REQ-026 Bypass-path latency SHALL be: handshake at edge T -> out_valid=1 in the cycle after edge T (1 cycle).
REQ-027 In bypass, each component SHALL be expanded per BYPASS_EXPAND, and lut_ceb SHALL stay 0 for the whole pixel.
REQ-028 out_rgb SHALL change only on entry to OUT; in_rgb changes while busy SHALL have no effect.
REQ-029 No combinational path SHALL exist from in_valid or out_ready to in_ready, out_valid or lut_*.

Reset
REQ-030 While reset=1 at an edge, the state SHALL become IDLE, and out_valid, lut_ceb and lut_adb SHALL become 0, out_rgb 48'h0, and in_ready 1 from the next cycle.
REQ-031 Reset mid-pixel (any state) SHALL discard that pixel: no out_valid pulse SHALL occur for it, and lut_ceb SHALL be 0 in the cycle after reset.
REQ-032 in_valid SHALL be ignored while reset=1.

Verification
REQ-033 LUT model dout={~adb,adb}; in_rgb=24'h10_80_FF, bypass=0, out_ready=1 -> out_rgb=48'hEF10_7F80_00FF, out_valid 5 cycles after acceptance, lut_adb sequence 10,80,FF.
REQ-034 in_bypass=1, in_rgb=24'hA5_00_3C, BYPASS_EXPAND=1 -> out_rgb=48'hA5A5_0000_3C3C after 1 cycle, lut_ceb never high; with BYPASS_EXPAND=0 -> 48'hA500_0000_3C00.
REQ-035 out_ready=0 for 20 cycles in OUT -> out_valid and out_rgb held stable, in_ready=0 throughout, no LUT reads.
REQ-036 Back-to-back pixels, in_valid and out_ready high continuously -> one output every 6 cycles, in order, with no drops.
REQ-037 Reset asserted in RD_G -> no output for that pixel, in_ready=1 after reset, and the next pixel processes correctly.
